// File: rtl/fifo_pkg.sv
// Shared constants and types for the 128x8 show-ahead FIFO controller.
package fifo_pkg;

  localparam int FIFO_DW       = 8;
  localparam int FIFO_AW       = 7;
  localparam int FIFO_DEPTH    = 1 << FIFO_AW;
  localparam int FIFO_AF_LEVEL = 120;

  // Pointer carries one extra wrap bit beyond the RAM address.
  typedef logic [FIFO_AW:0] fifo_ptr_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping AW+1-bit FIFO pointer with increment enable and synchronous active-low reset.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int AW = FIFO_AW
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        inc,
  output logic [AW:0] ptr
);

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ctl_128.sv
// Pointer/flag controller turning an external two-port RAM (sync write A, async read B)
// into a 128x8 fall-through FIFO.
module fifo_ctl_128
  import fifo_pkg::*;
#(
  parameter int          DW       = FIFO_DW,
  parameter int          AW       = FIFO_AW,
  parameter int unsigned AF_LEVEL = FIFO_AF_LEVEL
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  output logic [DW-1:0] ram_din,
  output logic [AW-1:0] ram_adr_a,
  output logic [AW-1:0] ram_adr_b,
  output logic          ram_we_n,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [AW:0] AF_THR = (AW+1)'(AF_LEVEL);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        push;
  logic        pop;

  // Gating with rst_n keeps the RAM write strobe inactive for the whole reset.
  assign push = wr_en & ~full & rst_n;
  assign pop  = rd_en & ~empty & rst_n;

  fifo_ptr #(.AW(AW)) u_wr_ptr (
    .ck    (ck),
    .rst_n (rst_n),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.AW(AW)) u_rd_ptr (
    .ck    (ck),
    .rst_n (rst_n),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  // Status comes only from registered pointers; no path from wr_en/rd_en.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = (count >= AF_THR);

  assign ram_din   = wr_data;
  assign ram_adr_a = wr_ptr[AW-1:0];
  assign ram_adr_b = rd_ptr[AW-1:0];
  assign ram_we_n  = ~push;
  assign rd_data   = ram_dout;

  // NOTE: reset clears only pointers and flags; the RAM array is left as-is, since
  // resetting the pointers already discards its contents.
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_ctl_128.sv
// Scoreboard bench for fifo_ctl_128 with a behavioural two-port RAM beside it.
module tb_fifo_ctl_128;
  import fifo_pkg::*;

  logic                ck = 1'b0;
  logic                rst_n;
  logic                wr_en;
  logic [FIFO_DW-1:0]  wr_data;
  logic                rd_en;
  logic [FIFO_DW-1:0]  rd_data;
  logic                empty;
  logic                full;
  logic                almost_full;
  fifo_ptr_t           count;
  logic                overflow;
  logic                underflow;
  logic [FIFO_DW-1:0]  ram_din;
  logic [FIFO_AW-1:0]  ram_adr_a;
  logic [FIFO_AW-1:0]  ram_adr_b;
  logic                ram_we_n;
  logic [FIFO_DW-1:0]  ram_dout;

  logic [FIFO_DW-1:0]  mem [FIFO_DEPTH];

  int n_checks = 0;
  int n_pass   = 0;

  logic [FIFO_DW-1:0] sbq [$];
  int mcount = 0;
  bit m_ovf  = 0;
  bit m_udf  = 0;

  fifo_ctl_128 dut (
    .ck          (ck),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .ram_din     (ram_din),
    .ram_adr_a   (ram_adr_a),
    .ram_adr_b   (ram_adr_b),
    .ram_we_n    (ram_we_n),
    .ram_dout    (ram_dout)
  );

  always #5 ck = ~ck;

  always @(posedge ck) begin
    if (!ram_we_n) mem[ram_adr_a] <= ram_din;
  end
  assign ram_dout = mem[ram_adr_b];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop presents a word that must match the scoreboard head.
  always @(negedge ck) begin
    if (rst_n === 1'b1 && rd_en === 1'b1 && empty === 1'b0) begin
      if (sbq.size() == 0) begin
        n_checks++;
        $display("FAIL sb_underrun: DUT popped 0x%0h, expected no word (t=%0t)", rd_data, $time);
      end else begin
        check("pop_data", 32'(rd_data), 32'(sbq.pop_front()));
      end
    end
  end

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(count), 32'(mcount));
    check({tag, "_empty"}, 32'(empty), 32'(mcount == 0));
    check({tag, "_full"}, 32'(full), 32'(mcount == FIFO_DEPTH));
    check({tag, "_afull"}, 32'(almost_full), 32'(mcount >= FIFO_AF_LEVEL));
    check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_udf"}, 32'(underflow), 32'(m_udf));
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic step(input logic we, input logic [FIFO_DW-1:0] wd, input logic re);
    bit push_ok;
    bit pop_ok;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    push_ok = we && (mcount < FIFO_DEPTH);
    pop_ok  = re && (mcount > 0);
    if (we && !push_ok) m_ovf = 1'b1;
    if (re && !pop_ok)  m_udf = 1'b1;
    if (push_ok) sbq.push_back(wd);
    @(posedge ck);
    #1;
    mcount = mcount + int'(push_ok) - int'(pop_ok);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'hE7;
    for (int i = 0; i < cycles; i++) begin
      @(negedge ck);
      check("reset_we_n", 32'(ram_we_n), 32'd1);
      @(posedge ck);
    end
    #1;
    rst_n = 1'b1;
    wr_en = 1'b0;
    sbq.delete();
    mcount = 0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b1;
    wr_data = '0;
    rd_en   = 1'b0;

    // Reset with wr_en held high.
    do_reset(3);
    check_status("post_reset");

    // Fill 0x00..0x7F, then drain in order.
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0);
      check_status("fill");
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check_status("drain");
    end

    // Overflow while full, then a simultaneous push/pop at full.
    for (int i = 0; i < FIFO_DEPTH; i++) step(1'b1, 8'(i + 8'h30), 1'b0);
    check_status("full");
    step(1'b1, 8'hAA, 1'b0);
    check_status("ovf_push");
    step(1'b1, 8'hAB, 1'b1);
    check_status("full_push_pop");
    for (int i = 0; i < FIFO_DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1);
    check_status("ovf_drained");

    // Empty with simultaneous push 0x5C and pop.
    step(1'b1, 8'h5C, 1'b1);
    check_status("empty_push_pop");
    check("fallthrough_5c", 32'(rd_data), 32'h5C);
    step(1'b0, 8'h00, 1'b1);
    check_status("udf_drained");

    // Streaming one push and one pop per cycle over several pointer wraps.
    do_reset(1);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(i), 1'b0);
    for (int k = 0; k < 600; k++) begin
      step(1'b1, 8'(10 + k), 1'b1);
      check("stream_count", 32'(count), 32'd10);
    end
    check_status("stream_end");
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);
    check_status("stream_drained");

    // Mid-stream reset with 50 words stored.
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 50; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    check_status("pre_midreset");
    do_reset(1);
    check_status("post_midreset");
    step(1'b1, 8'h11, 1'b0);
    check("after_reset_11", 32'(rd_data), 32'h11);
    check_status("after_reset_push");
    step(1'b0, 8'h00, 1'b1);
    check_status("final");
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
